// File: rtl/load_align_stage.sv
// MEM2 load-alignment stage: registers the raw memory word and load attributes,
// then extracts and sign/zero-extends the addressed byte/halfword/word.

package load_align_pkg;
  typedef logic [1:0] load_type_t;
  localparam load_type_t BYTE     = 2'd0;
  localparam load_type_t HALFWORD = 2'd1;
  localparam load_type_t WORD     = 2'd2;
endpackage

module load_align_stage
  import load_align_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RD_BITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    in_addr,
  input  load_type_t         in_how_much,
  input  logic               in_unsigned,
  input  logic [RD_BITS-1:0] in_rd,
  input  logic [XLEN-1:0]    mem_content,
  output logic               out_valid,
  output logic [RD_BITS-1:0] out_rd,
  output logic [XLEN-1:0]    out_data,
  output logic               out_misaligned,
  output logic [XLEN-1:0]    out_addr
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  logic               valid_q;
  logic [XLEN-1:0]    addr_q;
  load_type_t         how_much_q;
  logic               unsigned_q;
  logic [RD_BITS-1:0] rd_q;
  logic [XLEN-1:0]    raw_q;

  // MEM2 pipeline register; flush only kills valid, the payload is don't-care
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      how_much_q <= WORD;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
      raw_q      <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
    end else if (!stall) begin
      valid_q    <= in_valid;
      addr_q     <= in_addr;
      how_much_q <= in_how_much;
      unsigned_q <= in_unsigned;
      rd_q       <= in_rd;
      raw_q      <= mem_content;
    end
  end

  logic [BYTE_W-1:0] lane [4];
  logic [1:0]        offset;
  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;
  logic [XLEN-1:0]   data_c;
  logic              misaligned_c;

  // Lane 0 is the most significant byte of the raw word
  always_comb begin
    lane[0]  = raw_q[31:24];
    lane[1]  = raw_q[23:16];
    lane[2]  = raw_q[15:8];
    lane[3]  = raw_q[7:0];
    offset   = addr_q[1:0];
    byte_sel = lane[offset];
    half_sel = {lane[{offset[1], 1'b1}], lane[{offset[1], 1'b0}]};
  end

  // Extraction and extension; unused how_much encoding behaves as WORD
  always_comb begin
    data_c       = '0;
    misaligned_c = 1'b0;
    case (how_much_q)
      BYTE: begin
        data_c = unsigned_q ? {{(XLEN-BYTE_W){1'b0}}, byte_sel}
                            : {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      end
      HALFWORD: begin
        if (offset[0]) begin
          misaligned_c = 1'b1;
        end else begin
          data_c = unsigned_q ? {{(XLEN-HALF_W){1'b0}}, half_sel}
                              : {{(XLEN-HALF_W){half_sel[HALF_W-1]}}, half_sel};
        end
      end
      default: begin
        if (offset != 2'd0) begin
          misaligned_c = 1'b1;
        end else begin
          data_c = raw_q;
        end
      end
    endcase
  end

  assign out_valid      = valid_q;
  assign out_rd         = rd_q;
  assign out_addr       = addr_q;
  assign out_data       = valid_q ? data_c : '0;
  assign out_misaligned = valid_q & misaligned_c;

endmodule

// File: doc/load_align_stage.md
Name: load_align_stage

Overview:
- Pipeline stage directly downstream of the data memory read port in the 7-stage core (MEM1 -> MEM2 boundary).
- Captures the full 32-bit word returned by memory together with the load's address offset, type, signedness and destination register.
- In the next cycle, produces the architecturally correct load result: byte or halfword extraction, sign/zero extension, and misalignment flagging for writeback.
- Upstream always issues the memory read as `WORD`; all sub-word handling lives here.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RD_BITS, 5, width of the destination register index.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the MEM2 register contents
- flush  in  1  kill the instruction entering MEM2
- in_valid  in  1  MEM1 holds a valid load
- in_addr  in  32  word_address of the load; only bits [1:0] are used here
- in_how_much  in  load_type  `BYTE` / `HALFWORD` / `WORD` (encodings from definitions.vh)
- in_unsigned  in  1  1 = LBU/LHU zero-extend
- in_rd  in  RD_BITS  destination register
- mem_content  in  32  word from data memory for in_addr (combinational, same cycle)
- out_valid  out  1  MEM2 result valid
- out_rd  out  RD_BITS  destination register
- out_data  out  32  aligned and extended load result
- out_misaligned  out  1  misaligned-access trap request
- out_addr  out  32  captured full address, for trap reporting

Behaviour:
- Registers captured on every rising clk edge: valid, addr, how_much, unsigned, rd, raw word.
- Priority at each edge: reset > flush > stall > load.
- reset: out_valid=0, out_rd=0, out_addr=0, raw word=0, how_much=`WORD`, unsigned=0.
  - Consequently out_data=0 and out_misaligned=0.
  - Reset mid-stall or mid-flush clears everything in the same edge.
- flush: valid register <= 0; the other registers may load or hold (don't-care), but out_data must read 0 while out_valid=0.
  - flush together with stall still clears valid.
- stall (no flush): all registers hold; outputs are stable across any number of stalled cycles.
- normal: all registers load from in_*; the valid register <= in_valid.
- Latency: one cycle from the MEM1 capture edge to the outputs; outputs are combinational from the registers only. There is no path from in_* to out_*.
- Lane mapping of the raw word R:
  - lane0 = R[31:24], lane1 = R[23:16], lane2 = R[15:8], lane3 = R[7:0].
  - Byte offset k = addr[1:0] selects lane k.
- `BYTE`: b = lane[addr[1:0]]; out_data = sign- or zero-extended b, per the unsigned flag.
- `HALFWORD`: requires addr[0]=0.
  - h = {lane[addr[1:0]+1], lane[addr[1:0]]}, i.e. the lower-address byte is the low byte.
  - out_data = extended h.
- `WORD`: requires addr[1:0]=0; out_data = R unchanged. The unsigned flag is ignored.
- Misaligned (`HALFWORD` with addr[0]=1, or `WORD` with addr[1:0]!=0):
  - out_misaligned=1 and out_data=0; out_valid remains 1.
  - out_misaligned is 0 whenever out_valid=0.
- Unused encoding of how_much: treat as `WORD`.
- out_addr, out_rd reflect the captured values; they are don't-care when out_valid=0 except after reset, where they are 0.

Test Plan:
- Reset held for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_misaligned=0, out_rd=0.
- LB, offset 0, mem_content=0x80FF7F01, rd=5 -> next cycle out_data=0xFFFFFF80, out_rd=5; same input with in_unsigned=1 -> 0x00000080.
- LH, offset 2, mem_content=0x80FF7F01 -> 0x0000017F; LH offset 0 -> 0xFFFFFF80; LHU offset 0 -> 0x0000FF80.
- LW, offset 0, mem_content=0xDEADBEEF -> 0xDEADBEEF; LW offset 2 -> out_misaligned=1, out_data=0, out_valid=1, out_addr=in_addr.
- Stall 3 cycles after an LB result 0x0000007F while inputs change -> outputs stay 0x0000007F and valid for all 3 cycles; on release, the next load appears one cycle later.
- flush=1 and stall=1 in the same cycle with in_valid=1 -> next cycle out_valid=0, out_data=0; back-to-back loads without stall produce one result per cycle in order.
